// File: rtl/instruction_fetch.sv
// Fetch stage: runs the req/ack handshake with instruction memory for the current pc,
// fills the IF/ID register and pulses pc_en once per accepted fetch.
module instruction_fetch #(
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 255,
  parameter logic [DATA_W-1:0] RESET_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc,
  output logic              pc_en,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              flush,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  output logic              fetch_error
);

  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, ERR} state_t;

  state_t            state, state_nxt;
  logic              req_nxt, valid_nxt, err_nxt, drop, drop_nxt;
  logic [DATA_W-1:0] addr_nxt, instr_nxt, instr_pc_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  // pc_en fires in the ack cycle itself so program_counter has already stepped by the
  // time the next IDLE cycle samples pc; that is what allows one fetch every two cycles.
  assign pc_en = (state == WAIT) && imem_ack && !drop && !flush;

  always_comb begin
    state_nxt    = state;
    req_nxt      = imem_req;
    addr_nxt     = imem_addr;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    valid_nxt    = instr_valid;
    err_nxt      = fetch_error;
    drop_nxt     = drop;
    cnt_nxt      = cnt;

    if (instr_valid && !stall) valid_nxt = 1'b0;
    if (flush && state != ERR) begin
      valid_nxt = 1'b0;
      instr_nxt = RESET_INSTR;
    end

    case (state)
      IDLE: begin
        if (fetch_error) begin
          state_nxt = ERR;
        end else if (pc[1:0] != 2'b00) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = ERR;
        end else if (flush) begin
          // Wait one cycle so the request picks up the redirected pc.
          state_nxt = IDLE;
        end else if (instr_valid && stall) begin
          state_nxt = HOLD;
        end else begin
          req_nxt   = 1'b1;
          addr_nxt  = pc;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          drop_nxt  = 1'b0;
          state_nxt = IDLE;
          if (!drop && !flush) begin
            instr_nxt    = imem_rdata;
            instr_pc_nxt = imem_addr;
            valid_nxt    = 1'b1;
          end
        end else begin
          if (flush) drop_nxt = 1'b1;
          if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            err_nxt   = 1'b1;
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
            drop_nxt  = 1'b0;
            state_nxt = ERR;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (flush || !stall) state_nxt = IDLE;
      end
      ERR: begin
        req_nxt   = 1'b0;
        valid_nxt = 1'b0;
      end
      default: state_nxt = ERR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= RESET_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_error <= 1'b0;
      drop        <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      instr_valid <= valid_nxt;
      fetch_error <= err_nxt;
      drop        <= drop_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/flush/ack traffic
// against a transaction-level reference of the fetch rules; also acts as memory and PC.
module tb_instruction_fetch;

  localparam int          TO     = 4;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: outstanding request, whether its data is killed, cycles waited,
  // IF/ID contents, sticky error, and whether decode is being held off.
  bit          m_busy, m_kill, m_err, m_v, m_held;
  logic [31:0] m_addr, m_instr, m_ipc;
  int          m_wait;

  instruction_fetch #(.DATA_W(32), .TIMEOUT(TO), .RESET_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("imem_req", imem_req, m_busy);
    chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", instr_valid, m_v);
    chk("instr", instr, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("fetch_error", fetch_error, m_err);
  endtask

  // Entered at posedge+1; asserts reset asynchronously and releases it one edge later.
  task automatic reset_dut();
    rst = 1'b1;
    stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0; pc = '0;
    m_busy = 0; m_kill = 0; m_err = 0; m_v = 0; m_held = 0;
    m_addr = '0; m_instr = NOP; m_ipc = '0; m_wait = 0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict, advance, compare.
  task automatic step(input logic stl, input logic fl, input logic ack,
                      input logic [31:0] rd, input logic [31:0] tgt);
    bit          pe, n_busy, n_kill, n_err, n_v, n_held;
    logic [31:0] n_addr, n_instr, n_ipc, pc_nx;
    int          n_wait;
    stall = stl; flush = fl; imem_ack = ack; imem_rdata = rd;

    pe     = m_busy && ack && !m_kill && !fl;
    n_busy = m_busy; n_kill = m_kill; n_err = m_err; n_held = 1'b0;
    n_addr = m_addr; n_instr = m_instr; n_ipc = m_ipc; n_wait = m_wait;
    n_v    = m_v && stl;
    if (!m_err && fl) begin
      n_v = 0;
      n_instr = NOP;
    end
    if (m_err) begin
      n_v = 0;
    end else if (m_busy) begin
      if (ack) begin
        n_busy = 0; n_kill = 0;
        if (pe) begin n_v = 1; n_instr = rd; n_ipc = m_addr; end
      end else begin
        if (fl) n_kill = 1;
        if (m_wait == TO - 1) begin n_err = 1; n_busy = 0; n_v = 0; n_kill = 0; end
        else n_wait = m_wait + 1;
      end
    end else if (m_held) begin
      n_held = stl && !fl;
    end else begin
      if (pc[1:0] != 2'b00) begin n_err = 1; n_v = 0; end
      else if (fl) begin end
      else if (m_v && stl) n_held = 1;
      else begin n_busy = 1; n_addr = pc; n_wait = 0; end
    end
    pc_nx = fl ? tgt : (pe ? pc + 32'd4 : pc);

    #1 chk("pc_en", pc_en, pe);
    @(posedge clk); #1;
    m_busy = n_busy; m_kill = n_kill; m_err = n_err; m_v = n_v; m_held = n_held;
    m_addr = n_addr; m_instr = n_instr; m_ipc = n_ipc; m_wait = n_wait;
    pc = pc_nx;
    chk_outputs();
  endtask

  initial begin
    bit          s, f, a;
    logic [31:0] t;
    int          errc;
    @(posedge clk); #1;
    reset_dut();

    // Basic fetch with single-cycle memory
    step(0, 0, 0, 0, 0);
    chk("basic_req", imem_req, 1);
    step(0, 0, 1, 32'h2008_0005, 0);
    chk("basic_valid", instr_valid, 1);
    chk("basic_instr", instr, 32'h2008_0005);
    step(0, 0, 0, 0, 0);
    chk("next_addr", imem_addr, 32'h4);

    // Decode stall for 5 cycles, then release
    step(0, 0, 1, 32'h1234_5678, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    chk("stall_instr", instr, 32'h1234_5678);
    chk("stall_ipc", instr_pc, 32'h4);
    step(0, 0, 0, 0, 0);
    chk("stall_consumed", instr_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("stall_rel_req", imem_req, 1);

    // Flush while waiting, ack three cycles later
    step(0, 1, 0, 0, 32'h0000_0100);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hDEAD_BEEF, 0);
    chk("flush_valid", instr_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("flush_addr", imem_addr, 32'h0000_0100);
    step(0, 0, 1, 32'h0BAD_F00D, 0);

    // Misaligned pc
    reset_dut();
    pc = 32'h0000_0006;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 32'h0000_0006);
      chk("mis_err", fetch_error, 1);
      chk("mis_req", imem_req, 0);
    end

    // Timeout with ack withheld
    reset_dut();
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    chk("to_err_early", fetch_error, 0);
    step(0, 0, 0, 0, 0);
    chk("to_err", fetch_error, 1);
    chk("to_req", imem_req, 0);

    // Reset mid-request, stray ack afterwards
    reset_dut();
    step(0, 0, 0, 0, 0);
    #2;
    reset_dut();
    step(0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("stray_valid", instr_valid, 0);

    // Randomized traffic
    errc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_err) begin
        errc++;
        if (errc > 2) begin
          reset_dut();
          errc = 0;
          continue;
        end
      end
      s = ($urandom % 10) < 3;
      f = ($urandom % 100) < 8;
      a = m_busy && (($urandom % 10) < 7);
      t = 32'($urandom_range(0, 16383)) << 2;
      if (($urandom % 100) < 3) t = t | 32'h2;
      step(s, f, a, $urandom, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
